cv32e40p_prefetch_buffer_mo: RTL and testbench
==============================================

// Module: cv32e40p_prefetch_buffer_mo
// PURPOSE
//  Multi-outstanding instruction prefetch buffer between the IF stage and the OBI instruction bus.
//  Successor of the fixed depth-2 prefetcher, with these additions:
//   - parametrised FIFO depth and outstanding-transaction limit;
//   - OBI-compliant request stability;
//   - bus error propagated per instruction word;
//   - counted discard of stale responses after a branch.
// PARAMETERS
//  DEPTH            4      FIFO entries; power of 2, >= 2
//  MAX_OUTSTANDING  DEPTH  max granted-but-unanswered transactions; 1..DEPTH
//  RESET_ADDR       32'h0  fetch address used if req_i rises before any branch
// PORTS
//  clk            in   1   clock, all logic on rising edge
//  rst            in   1   synchronous, active-high reset
//  req_i          in   1   fetching enabled
//  branch_i       in   1   redirect fetch to branch_addr_i (only with req_i=1)
//  branch_addr_i  in   32  branch target, halfword aligned
//  fetch_ready_i  in   1   IF accepts fetch word
//  fetch_valid_o  out  1   fetch word valid
//  fetch_rdata_o  out  32  fetch word
//  fetch_err_o    out  1   bus error on this word; qualified by fetch_valid_o
//  instr_req_o    out  1   OBI request
//  instr_gnt_i    in   1   OBI grant
//  instr_addr_o   out  32  OBI address; bits [1:0] always 0
//  instr_rdata_i  in   32  OBI read data
//  instr_rvalid_i in   1   OBI response valid
//  instr_err_i    in   1   OBI error; qualified by instr_rvalid_i
//  busy_o         out  1   requests pending or outstanding
// BEHAVIOUR
//  Reset: all outputs 0; addr_q=RESET_ADDR; outstanding=0; discard=0; FIFO empty; FSM=IDLE.
//  Credit rule: issue allowed iff outstanding+fifo_cnt < DEPTH and outstanding < MAX_OUTSTANDING.
//   Both counters are (clog2(DEPTH)+1) bits wide and never exceed DEPTH.
//  FSM states: IDLE, ISSUE, HOLD.
//   IDLE: instr_req_o=0. Go to ISSUE when req_i=1 and credit is available.
//   ISSUE: instr_req_o=1, instr_addr_o={addr_q[31:2],2'b00}.
//    - gnt=1: addr_q+=4 (wraps modulo 2^32); outstanding+=1. Stay in ISSUE while credit
//      remains and req_i=1, else go to IDLE.
//    - gnt=0: req and addr are frozen until granted (no retraction, no address change).
//   branch_i in IDLE, or in ISSUE with gnt=1: addr_q=branch_addr_i.
//   branch_i in ISSUE with gnt=0: store target in tgt_q; go to HOLD.
//   HOLD: keep stale request until gnt; then addr_q=tgt_q, and that response is discarded.
//   A later branch_i in HOLD overwrites tgt_q.
//  Discard: on branch_i (or the HOLD grant), discard = outstanding after this cycle's
//   gnt/rvalid update. Responses arriving while discard>0 are dropped; each one
//   decrements discard and outstanding.
//  Responses: each non-discarded rvalid decrements outstanding.
//   - Push {err,rdata} into FIFO, unless the FIFO is empty and fetch_ready_i=1:
//     fall-through, same-cycle valid, no push.
//   - FIFO can never overflow (credit rule); overflow is an assertion error.
//  Fetch output:
//   - fetch_valid_o = !branch_i && (!empty || (rvalid && discard==0)).
//   - Data/err come from the FIFO head if non-empty, else from the bus.
//   - Pop when fetch_valid_o && fetch_ready_i && !empty.
//  Branch: flush the FIFO the same cycle; fetch_valid_o=0 that cycle.
//  req_i=0: no new requests; outstanding responses are still accepted into the FIFO.
//  Error: instr_err_i is carried with the word; prefetching continues (no stop).
//  busy_o = instr_req_o || outstanding!=0.
//  Latency: first fetch_valid_o in the cycle rvalid arrives (fall-through); min 2 cycles
//   from branch_i with gnt and rvalid at zero wait.
//  Simultaneous gnt+rvalid: outstanding unchanged.
//  Simultaneous push+pop on a full FIFO: allowed.
//  rst mid-transfer: state returns to reset values. Bus responses after rst are
//   ignored (outstanding=0); the bench must not send them.
// TESTING
//  1 Zero-wait stream: branch to 0x100, gnt and rvalid every cycle, ready=1
//    -> addresses 0x100,0x104,...; data out in order; max outstanding = MAX_OUTSTANDING.
//  2 Backpressure: ready=0, DEPTH=4
//    -> exactly 4 grants, instr_req_o=0 afterwards; FIFO full; no data lost when ready=1.
//  3 Branch with 3 outstanding, target 0x200
//    -> 3 responses dropped; first fetch word is from 0x200; fetch_valid_o=0 in the branch cycle.
//  4 Branch while gnt held low 5 cycles at 0x40, target 0x80
//    -> instr_addr_o stays 0x40 until gnt; next request is 0x80; 0x40 data discarded.
//  5 instr_err_i=1 on the response for 0x108
//    -> fetch_err_o=1 with that word only; following words err=0.
//  6 Address wrap: branch to 0xFFFFFFFC
//    -> next request at 0x00000000.

Source files
------------

// File: rtl/cv32e40p_prefetch_buffer_mo.sv
// Multi-outstanding instruction prefetch buffer: credit-limited OBI fetcher feeding a FIFO
// with fall-through, per-word bus error and counted discard of stale responses.
module cv32e40p_prefetch_buffer_mo #(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = DEPTH,
   parameter logic [31:0] RESET_ADDR      = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        branch_i,
   input  logic [31:0] branch_addr_i,
   input  logic        fetch_ready_i,
   output logic        fetch_valid_o,
   output logic [31:0] fetch_rdata_o,
   output logic        fetch_err_o,
   output logic        instr_req_o,
   input  logic        instr_gnt_i,
   output logic [31:0] instr_addr_o,
   input  logic [31:0] instr_rdata_i,
   input  logic        instr_rvalid_i,
   input  logic        instr_err_i,
   output logic        busy_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   state_t        state_q;
   logic [31:0]   addr_q;
   logic [31:0]   tgt_q;
   logic [CW-1:0] outstanding_q;
   logic [CW-1:0] discard_q;
   logic [CW-1:0] fifo_cnt_q;
   logic [AW-1:0] rptr_q;
   logic [AW-1:0] wptr_q;
   logic [32:0]   mem_q [DEPTH];

   logic          gnt_hs;
   logic          fifo_empty;
   logic          disc_zero;
   logic          push;
   logic          pop;
   logic          credit_next;
   logic [CW-1:0] outstanding_n;
   logic [CW-1:0] fifo_cnt_n;
   logic [32:0]   head;

   assign instr_req_o  = (state_q != IDLE);
   assign instr_addr_o = {addr_q[31:2], 2'b00};
   assign busy_o       = instr_req_o || (outstanding_q != '0);

   assign gnt_hs     = instr_req_o && instr_gnt_i;
   assign fifo_empty = (fifo_cnt_q == '0);
   assign disc_zero  = (discard_q == '0);
   assign head       = mem_q[rptr_q];

   assign fetch_valid_o = !branch_i && (!fifo_empty || (instr_rvalid_i && disc_zero));
   assign fetch_rdata_o = !fetch_valid_o ? '0 : (fifo_empty ? instr_rdata_i : head[31:0]);
   assign fetch_err_o   = fetch_valid_o && (fifo_empty ? instr_err_i : head[32]);

   assign pop  = fetch_valid_o && fetch_ready_i && !fifo_empty;
   // An accepted response goes straight out when nothing is queued ahead of it.
   assign push = instr_rvalid_i && disc_zero && !branch_i && !(fifo_empty && fetch_ready_i);

   assign outstanding_n = outstanding_q + CW'(gnt_hs) - CW'(instr_rvalid_i);
   assign fifo_cnt_n    = branch_i ? '0 : (fifo_cnt_q + CW'(push) - CW'(pop));

   // Credit is judged on next-cycle counts so a request raised now can always be granted.
   assign credit_next = (({1'b0, outstanding_n} + {1'b0, fifo_cnt_n}) < (CW+1)'(DEPTH)) &&
                        (outstanding_n < CW'(MAX_OUTSTANDING));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         addr_q        <= RESET_ADDR;
         tgt_q         <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
         fifo_cnt_q    <= '0;
         rptr_q        <= '0;
         wptr_q        <= '0;
      end else begin
         outstanding_q <= outstanding_n;
         fifo_cnt_q    <= fifo_cnt_n;
         if (branch_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
         end else begin
            if (push) begin
               mem_q[wptr_q] <= {instr_err_i, instr_rdata_i};
               wptr_q        <= wptr_q + AW'(1);
            end
            if (pop) rptr_q <= rptr_q + AW'(1);
         end
         if (instr_rvalid_i && !disc_zero) discard_q <= discard_q - CW'(1);

         case (state_q)
            IDLE: begin
               if (branch_i) begin
                  addr_q    <= branch_addr_i;
                  discard_q <= outstanding_n;
               end
               if (req_i && credit_next) state_q <= ISSUE;
            end
            ISSUE: begin
               if (gnt_hs) begin
                  addr_q  <= branch_i ? branch_addr_i : addr_q + 32'd4;
                  if (branch_i) discard_q <= outstanding_n;
                  state_q <= (req_i && credit_next) ? ISSUE : IDLE;
               end else if (branch_i) begin
                  tgt_q     <= branch_addr_i;
                  discard_q <= outstanding_n;
                  state_q   <= HOLD;
               end
            end
            HOLD: begin
               // The stale request stays on the bus; its grant is counted into discard.
               if (branch_i) tgt_q <= branch_addr_i;
               if (gnt_hs) begin
                  addr_q    <= branch_i ? branch_addr_i : tgt_q;
                  discard_q <= outstanding_n;
                  state_q   <= (req_i && credit_next) ? ISSUE : IDLE;
               end else if (branch_i) begin
                  discard_q <= outstanding_n;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && !pop && (fifo_cnt_q == CW'(DEPTH))));
      end
   end

endmodule

// File: tb/tb_cv32e40p_prefetch_buffer_mo.sv
// Bench for the prefetch buffer: OBI memory model with random latency, and an expected
// fetch stream that restarts at every branch target and advances one word per accept.
module tb_cv32e40p_prefetch_buffer_mo;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned MAXO  = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_i, branch_i, fetch_ready_i;
   logic [31:0] branch_addr_i;
   logic        fetch_valid_o, fetch_err_o;
   logic [31:0] fetch_rdata_o;
   logic        instr_req_o, instr_gnt_i;
   logic [31:0] instr_addr_o, instr_rdata_i;
   logic        instr_rvalid_i, instr_err_i;
   logic        busy_o;

   always #5 clk = ~clk;

   cv32e40p_prefetch_buffer_mo #(
      .DEPTH(DEPTH),
      .MAX_OUTSTANDING(MAXO),
      .RESET_ADDR(32'h0)
   ) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
      .fetch_ready_i(fetch_ready_i), .fetch_valid_o(fetch_valid_o), .fetch_rdata_o(fetch_rdata_o),
      .fetch_err_o(fetch_err_o), .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i),
      .instr_addr_o(instr_addr_o), .instr_rdata_i(instr_rdata_i), .instr_rvalid_i(instr_rvalid_i),
      .instr_err_i(instr_err_i), .busy_o(busy_o)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int unsigned rv_pct = 100;
   logic        err_en = 1'b0;
   logic [31:0] err_addr = 32'h0;
   logic [31:0] exp_addr;
   logic [31:0] pend_addr [$];
   int          pend_cyc [$];

   logic        o_fv, o_fe, o_req, o_busy, o_rv, o_ghs;
   logic [31:0] o_fd, o_addr, o_rv_addr;
   int          o_pend;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   function automatic logic err_of(input logic [31:0] a);
      return err_en && (a == err_addr);
   endfunction

   // One clock: drive inputs and the bus response at negedge, sample 1 ns later,
   // then update the outstanding-transaction queue of the memory model.
   task automatic tick(input logic br, input logic [31:0] ba, input logic rq,
                       input logic rdy, input logic g);
      logic rv;
      @(negedge clk);
      req_i = rq; branch_i = br; branch_addr_i = ba; fetch_ready_i = rdy; instr_gnt_i = g;
      rv = 1'b0;
      if (pend_addr.size() != 0)
         if (pend_cyc[0] < cyc && $urandom_range(99) < rv_pct) rv = 1'b1;
      instr_rvalid_i = rv;
      o_rv_addr      = rv ? pend_addr[0] : 32'h0;
      instr_rdata_i  = rv ? data_of(o_rv_addr) : $urandom();
      instr_err_i    = rv ? err_of(o_rv_addr) : 1'($urandom_range(1));
      #1;
      o_pend = pend_addr.size();
      o_fv = fetch_valid_o; o_fd = fetch_rdata_o; o_fe = fetch_err_o;
      o_req = instr_req_o; o_addr = instr_addr_o; o_busy = busy_o;
      o_ghs = instr_req_o && g;
      o_rv  = rv;
      if (rv) begin
         void'(pend_addr.pop_front());
         void'(pend_cyc.pop_front());
      end
      if (o_ghs) begin
         pend_addr.push_back(instr_addr_o);
         pend_cyc.push_back(cyc);
      end
      cyc++;
   endtask

   task automatic do_reset;
      pend_addr.delete();
      pend_cyc.delete();
      rst = 1'b1;
      repeat (3) tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({o_fv, o_req, o_busy, o_fe} !== 4'b0 || o_addr !== 32'h0 || o_fd !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: got fv=%b req=%b busy=%b err=%b addr=%h data=%h, want all 0",
                  o_fv, o_req, o_busy, o_fe, o_addr, o_fd);
      end
      tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (o_req !== 1'b1 || o_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_addr: got req=%b addr=%h, want 1/00000000", o_req, o_addr);
      end
      rv_pct = 100;
      repeat (3) tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      do_reset();
      tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (o_req !== 1'b0 || o_busy !== 1'b0 || o_fv !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got req=%b busy=%b fv=%b, want 0/0/0", o_req, o_busy, o_fv);
      end
   endtask

   task automatic test_stream;
      logic [31:0] exp_gnt;
      int words, peak;
      do_reset();
      rv_pct = 100;
      tick(1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
      exp_addr = 32'h100; exp_gnt = 32'h100; words = 0; peak = 0;
      for (int i = 1; i <= 20; i++) begin
         tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
         if (o_ghs) begin
            checks++;
            if (o_addr !== exp_gnt) begin
               errors++;
               $display("FAIL stream_addr: got %h want %h", o_addr, exp_gnt);
            end
            exp_gnt += 32'd4;
         end
         if (i == 2) begin
            checks++;
            if (o_fv !== 1'b1) begin
               errors++;
               $display("FAIL stream_latency: fetch_valid_o got %b want 1 two cycles after branch", o_fv);
            end
         end
         if (o_fv && fetch_ready_i) begin
            checks++;
            if (o_fd !== data_of(exp_addr) || o_fe !== err_of(exp_addr)) begin
               errors++;
               $display("FAIL stream_word: addr %h got %h/%b want %h/%b", exp_addr, o_fd, o_fe,
                        data_of(exp_addr), err_of(exp_addr));
            end
            exp_addr += 32'd4; words++;
         end
         if (o_pend > peak) peak = o_pend;
      end
      checks++;
      if (words != 19) begin
         errors++;
         $display("FAIL stream_count: got %0d words want 19", words);
      end
      checks++;
      if (peak > int'(MAXO)) begin
         errors++;
         $display("FAIL stream_outstanding: peak %0d exceeds %0d", peak, MAXO);
      end
   endtask

   task automatic test_backpressure;
      int grants, words;
      do_reset();
      rv_pct = 100;
      tick(1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
      exp_addr = 32'h300; grants = 0; words = 0;
      for (int i = 0; i < 12; i++) begin
         tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
         if (o_ghs) grants++;
      end
      checks++;
      if (grants != int'(DEPTH)) begin
         errors++;
         $display("FAIL bp_grants: got %0d want %0d", grants, DEPTH);
      end
      checks++;
      if (o_req !== 1'b0) begin
         errors++;
         $display("FAIL bp_req_stop: instr_req_o got %b want 0", o_req);
      end
      checks++;
      if (o_fv !== 1'b1 || o_fd !== data_of(32'h300)) begin
         errors++;
         $display("FAIL bp_head: got fv=%b data=%h want 1/%h", o_fv, o_fd, data_of(32'h300));
      end
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
         if (o_fv && fetch_ready_i) begin
            checks++;
            if (o_fd !== data_of(exp_addr) || o_fe !== err_of(exp_addr)) begin
               errors++;
               $display("FAIL bp_word: addr %h got %h/%b want %h/%b", exp_addr, o_fd, o_fe,
                        data_of(exp_addr), err_of(exp_addr));
            end
            exp_addr += 32'd4; words++;
         end
      end
      checks++;
      if (words < 12) begin
         errors++;
         $display("FAIL bp_drain: got %0d words want at least 12", words);
      end
   endtask

   task automatic test_branch_discard;
      int grants, dropped, words;
      do_reset();
      rv_pct = 0;
      tick(1'b1, 32'h500, 1'b1, 1'b1, 1'b0);
      grants = 0;
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
         if (o_ghs) grants++;
      end
      checks++;
      if (grants != int'(MAXO) || o_pend != int'(MAXO) || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL disc_fill: got grants=%0d outstanding=%0d busy=%b want %0d/%0d/1",
                  grants, o_pend, o_busy, MAXO, MAXO);
      end
      tick(1'b1, 32'h200, 1'b1, 1'b1, 1'b0);
      checks++;
      if (o_fv !== 1'b0) begin
         errors++;
         $display("FAIL disc_branch_valid: got %b want 0", o_fv);
      end
      exp_addr = 32'h200; rv_pct = 100; dropped = 0; words = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
         if (o_rv && o_rv_addr[31:8] == 24'h000005) begin
            dropped++;
            checks++;
            if (o_fv !== 1'b0) begin
               errors++;
               $display("FAIL disc_stale: response for %h got fv=%b want 0", o_rv_addr, o_fv);
            end
         end
         if (o_fv && fetch_ready_i) begin
            checks++;
            if (o_fd !== data_of(exp_addr) || o_fe !== err_of(exp_addr)) begin
               errors++;
               $display("FAIL disc_word: addr %h got %h/%b want %h/%b", exp_addr, o_fd, o_fe,
                        data_of(exp_addr), err_of(exp_addr));
            end
            exp_addr += 32'd4; words++;
         end
      end
      checks++;
      if (dropped != 3 || words < 10) begin
         errors++;
         $display("FAIL disc_count: got dropped=%0d words=%0d want 3/>=10", dropped, words);
      end
   endtask

   task automatic test_hold;
      int words;
      do_reset();
      rv_pct = 100;
      tick(1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         tick(i == 2, 32'h80, 1'b1, 1'b1, 1'b0);
         checks++;
         if (o_req !== 1'b1 || o_addr !== 32'h40 || (i == 2 && o_fv !== 1'b0)) begin
            errors++;
            $display("FAIL hold_stable: cycle %0d got req=%b addr=%h fv=%b want 1/00000040/0",
                     i, o_req, o_addr, o_fv);
         end
      end
      exp_addr = 32'h80;
      tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (o_ghs !== 1'b1 || o_addr !== 32'h40) begin
         errors++;
         $display("FAIL hold_grant: got gnt_hs=%b addr=%h want 1/00000040", o_ghs, o_addr);
      end
      words = 0;
      for (int i = 0; i < 15; i++) begin
         tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
         if (i == 0) begin
            checks++;
            if (o_req !== 1'b1 || o_addr !== 32'h80) begin
               errors++;
               $display("FAIL hold_next: got req=%b addr=%h want 1/00000080", o_req, o_addr);
            end
         end
         if (o_rv && o_rv_addr == 32'h40) begin
            checks++;
            if (o_fv !== 1'b0) begin
               errors++;
               $display("FAIL hold_discard: stale 0x40 response got fv=%b want 0", o_fv);
            end
         end
         if (o_fv && fetch_ready_i) begin
            checks++;
            if (o_fd !== data_of(exp_addr) || o_fe !== err_of(exp_addr)) begin
               errors++;
               $display("FAIL hold_word: addr %h got %h/%b want %h/%b", exp_addr, o_fd, o_fe,
                        data_of(exp_addr), err_of(exp_addr));
            end
            exp_addr += 32'd4; words++;
         end
      end
      checks++;
      if (words < 8) begin
         errors++;
         $display("FAIL hold_count: got %0d words want at least 8", words);
      end
   endtask

   task automatic test_error;
      logic saw;
      do_reset();
      rv_pct = 50; err_en = 1'b1; err_addr = 32'h108; saw = 1'b0;
      tick(1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
      exp_addr = 32'h100;
      for (int i = 0; i < 80; i++) begin
         tick(1'b0, 32'h0, 1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
         if (o_fv && fetch_ready_i) begin
            checks++;
            if (o_fd !== data_of(exp_addr) || o_fe !== err_of(exp_addr)) begin
               errors++;
               $display("FAIL err_word: addr %h got %h/%b want %h/%b", exp_addr, o_fd, o_fe,
                        data_of(exp_addr), err_of(exp_addr));
            end
            if (exp_addr == 32'h108) saw = 1'b1;
            exp_addr += 32'd4;
         end
      end
      checks++;
      if (saw !== 1'b1) begin
         errors++;
         $display("FAIL err_reached: word 0x108 got delivered=%b want 1", saw);
      end
      err_en = 1'b0;
   endtask

   task automatic test_wrap;
      logic [31:0] exp_gnt;
      int grants, words;
      do_reset();
      rv_pct = 100;
      tick(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
      exp_addr = 32'hFFFF_FFFC; exp_gnt = 32'hFFFF_FFFC; grants = 0; words = 0;
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
         if (o_ghs) begin
            checks++;
            if (o_addr !== exp_gnt) begin
               errors++;
               $display("FAIL wrap_addr: got %h want %h", o_addr, exp_gnt);
            end
            exp_gnt += 32'd4; grants++;
         end
         if (o_fv && fetch_ready_i) begin
            checks++;
            if (o_fd !== data_of(exp_addr) || o_fe !== err_of(exp_addr)) begin
               errors++;
               $display("FAIL wrap_word: addr %h got %h/%b want %h/%b", exp_addr, o_fd, o_fe,
                        data_of(exp_addr), err_of(exp_addr));
            end
            exp_addr += 32'd4; words++;
         end
      end
      checks++;
      if (grants < 2 || words < 4) begin
         errors++;
         $display("FAIL wrap_count: got grants=%0d words=%0d want >=2/>=4", grants, words);
      end
   endtask

   task automatic test_random;
      logic        br, rq, prev_stall;
      logic [31:0] ba, prev_addr;
      int          words;
      do_reset();
      exp_addr = 32'h0; prev_stall = 1'b0; prev_addr = 32'h0; words = 0;
      for (int i = 0; i < 4000; i++) begin
         if (i % 500 == 0) rv_pct = $urandom_range(100, 20);
         rq = ($urandom_range(9) != 0);
         br = rq && ($urandom_range(19) == 0);
         ba = $urandom() & 32'hFFFF_FFFE;
         tick(br, ba, rq, 1'($urandom_range(1)), 1'($urandom_range(1)));
         if (prev_stall) begin
            checks++;
            if (o_req !== 1'b1 || o_addr !== prev_addr) begin
               errors++;
               $display("FAIL rnd_stable: got req=%b addr=%h want 1/%h", o_req, o_addr, prev_addr);
            end
         end
         prev_stall = o_req && !instr_gnt_i;
         prev_addr  = o_addr;
         if (br) begin
            checks++;
            if (o_fv !== 1'b0) begin
               errors++;
               $display("FAIL rnd_branch_valid: got %b want 0", o_fv);
            end
            exp_addr = ba & 32'hFFFF_FFFC;
         end else if (o_fv && fetch_ready_i) begin
            checks++;
            if (o_fd !== data_of(exp_addr) || o_fe !== err_of(exp_addr)) begin
               errors++;
               $display("FAIL rnd_word: addr %h got %h/%b want %h/%b", exp_addr, o_fd, o_fe,
                        data_of(exp_addr), err_of(exp_addr));
            end
            exp_addr += 32'd4; words++;
         end
         checks++;
         if (o_busy !== (o_req || o_pend != 0) || o_pend > int'(MAXO) || o_addr[1:0] !== 2'b00) begin
            errors++;
            $display("FAIL rnd_status: got busy=%b outstanding=%0d addr=%h want busy=%b outstanding<=%0d addr[1:0]=0",
                     o_busy, o_pend, o_addr, (o_req || o_pend != 0), MAXO);
         end
      end
      checks++;
      if (words < 200) begin
         errors++;
         $display("FAIL rnd_progress: got %0d words want at least 200", words);
      end
   endtask

   initial begin
      rst = 1'b1; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = 32'h0; fetch_ready_i = 1'b0;
      instr_gnt_i = 1'b0; instr_rdata_i = 32'h0; instr_rvalid_i = 1'b0; instr_err_i = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_branch_discard();
      test_hold();
      test_error();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
